// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared opcode and FSM state encodings for mem_access_unit,
// plus small opcode classification helpers.
package mem_access_pkg;

  typedef enum logic [2:0] {
    OP_RD8    = 3'd0,
    OP_WR8    = 3'd1,
    OP_RD16   = 3'd2,
    OP_WR16   = 3'd3,
    OP_PUSH16 = 3'd4,
    OP_POP16  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BYTE0 = 2'd1,
    ST_BYTE1 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Encodings 6 and 7 are reserved and answered with an error response.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_POP16);
  endfunction

  function automatic logic op_is_write(input logic [2:0] op);
    return (op == OP_WR8) || (op == OP_WR16) || (op == OP_PUSH16);
  endfunction

  function automatic logic op_is_byte(input logic [2:0] op);
    return (op == OP_RD8) || (op == OP_WR8);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences 8/16-bit loads, stores and stack push/pop onto a
// byte-wide RAM with a combinational read port. 16-bit data is big-endian.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only when idle)
//   req_op, req_addr, req_wdata request opcode, byte address, write data
//   rsp_valid, rsp_rdata, rsp_err  one-cycle completion, read data, error flag
//   sp_out                      current stack pointer
//   mem_addr, mem_din, mem_we   RAM address, write data, write enable
//   mem_dout                    RAM read data
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// BYTE0 | first RAM access (MSB, or the only byte of an 8-bit op)
// BYTE1 | second RAM access (LSB), stack pointer updated at its edge
// RESP  | rsp_valid pulse, back to IDLE next cycle
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter logic [15:0] SP_INIT = 16'hFFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] sp_out,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  output logic        mem_we
);

  state_e      state_q;
  logic [2:0]  op_q;
  logic [7:0]  wdata_lo_q;
  logic [15:0] sp_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_din_q;
  logic        mem_we_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [15:0] rsp_rdata_q;
  logic [15:0] base_addr;

  // Address of the first (MSB) access; stack ops ignore req_addr.
  always_comb begin
    case (req_op)
      OP_PUSH16: base_addr = sp_q - 16'd1;
      OP_POP16:  base_addr = sp_q + 16'd1;
      default:   base_addr = req_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      wdata_lo_q  <= 8'h00;
      sp_q        <= SP_INIT;
      mem_addr_q  <= 16'h0000;
      mem_din_q   <= 8'h00;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            wdata_lo_q <= req_wdata[7:0];
            if (!op_is_legal(req_op)) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q    <= ST_BYTE0;
              mem_addr_q <= base_addr;
              mem_we_q   <= op_is_write(req_op);
              if (op_is_write(req_op))
                mem_din_q <= op_is_byte(req_op) ? req_wdata[7:0] : req_wdata[15:8];
            end
          end
        end
        ST_BYTE0: begin
          if (!op_is_write(op_q)) begin
            if (op_is_byte(op_q)) rsp_rdata_q <= {8'h00, mem_dout};
            else                  rsp_rdata_q[15:8] <= mem_dout;
          end
          if (op_is_byte(op_q)) begin
            state_q     <= ST_RESP;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
          end else begin
            state_q    <= ST_BYTE1;
            mem_addr_q <= mem_addr_q + 16'd1;
            mem_we_q   <= op_is_write(op_q);
            if (op_is_write(op_q)) mem_din_q <= wdata_lo_q;
          end
        end
        ST_BYTE1: begin
          if (!op_is_write(op_q)) rsp_rdata_q[7:0] <= mem_dout;
          if (op_q == OP_PUSH16) sp_q <= sp_q - 16'd2;
          if (op_q == OP_POP16)  sp_q <= sp_q + 16'd2;
          state_q     <= ST_RESP;
          mem_we_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sp_out    = sp_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  // The RAM samples mem_we at the same edge that applies reset, so the write
  // in flight is suppressed combinationally to abort cleanly.
  assign mem_we    = mem_we_q & ~reset;

endmodule
